// File: rtl/viterbi_traceback_param_if.sv
// Survivor-memory read bus and decoded-bit output stream of the Viterbi
// traceback unit.
//   sm_re / sm_page / sm_state : survivor read request (master -> memory)
//   sm_bit                     : decision bit, valid one cycle after sm_re
//   out_bit / out_valid / out_last / out_ready : decoded-bit valid/ready stream
// master = traceback unit, slave = survivor memory + downstream consumer.
interface viterbi_traceback_param_if #(
  parameter int SW = 6,
  parameter int PW = 6
);
  logic          sm_re;
  logic [PW-1:0] sm_page;
  logic [SW-1:0] sm_state;
  logic          sm_bit;
  logic          out_bit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output sm_re, sm_page, sm_state, out_bit, out_valid, out_last,
    input  sm_bit, out_ready
  );

  modport slave (
    input  sm_re, sm_page, sm_state, out_bit, out_valid, out_last,
    output sm_bit, out_ready
  );
endinterface

// File: rtl/viterbi_traceback_param.sv
// Parametrised Viterbi traceback unit.
// On start it walks TBD survivor pages backwards from start_page, beginning at
// start_state (or state 0 for a zero-tail frame), fetching one decision bit per
// step, then emits the OUT_LEN oldest decoded bits oldest-first.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, start_state, start_page, terminate : traceback request
//   abort               : synchronous return to IDLE, pending output dropped
//   bus (master)        : survivor read bus and decoded-bit stream
//   busy                : not IDLE
//   overrun             : sticky, start seen while busy
module viterbi_traceback_param #(
  parameter int SW      = 6,
  parameter int PW      = 6,
  parameter int TBD     = 64,
  parameter int OUT_LEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [SW-1:0] start_state,
  input  logic [PW-1:0] start_page,
  input  logic          terminate,
  input  logic          abort,
  viterbi_traceback_param_if.master bus,
  output logic          busy,
  output logic          overrun
);

  localparam int STW  = $clog2(TBD + 1);
  localparam int RIW  = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int SKIP = TBD - OUT_LEN;

  typedef enum logic [1:0] {IDLE, READ, WAIT, EMIT} fsm_t;

  fsm_t             fsm, fsm_nxt;
  logic [PW-1:0]    page_r;
  logic [SW-1:0]    trel_r;
  logic [STW-1:0]   step_r;
  logic [RIW-1:0]   rd_idx;
  logic [OUT_LEN-1:0] buf_r;
  logic [STW-1:0]   wr_idx;
  logic             keep;
  logic             xfer;
  logic             last_step;

  assign xfer      = (fsm == EMIT) && !abort && bus.out_ready;
  assign last_step = (step_r == STW'(TBD - 1));
  assign wr_idx    = step_r - STW'(SKIP);

  // Only the oldest OUT_LEN steps are kept; the newest SKIP decisions are
  // traced for convergence but never emitted.
  generate
    if (SKIP == 0) begin : g_keep_all
      assign keep = 1'b1;
    end else begin : g_keep_old
      assign keep = (step_r >= STW'(SKIP));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE: if (start)     fsm_nxt = READ;
      READ:                fsm_nxt = WAIT;
      WAIT: if (last_step) fsm_nxt = EMIT;
            else           fsm_nxt = READ;
      EMIT: if (xfer && (rd_idx == '0)) fsm_nxt = IDLE;
      default:             fsm_nxt = IDLE;
    endcase
    if (abort) fsm_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_r  <= '0;
      trel_r  <= '0;
      step_r  <= '0;
      rd_idx  <= '0;
      overrun <= 1'b0;
    end else begin
      if (start && (fsm != IDLE)) overrun <= 1'b1;
      unique case (fsm)
        IDLE: if (start && !abort) begin
          page_r <= start_page;
          trel_r <= terminate ? '0 : start_state;
          step_r <= '0;
        end
        WAIT: begin
          trel_r <= {trel_r[SW-2:0], bus.sm_bit};
          page_r <= page_r - PW'(1);
          step_r <= step_r + STW'(1);
          if (last_step) rd_idx <= RIW'(OUT_LEN - 1);
        end
        EMIT: if (xfer && (rd_idx != '0)) rd_idx <= rd_idx - RIW'(1);
        default: ;
      endcase
    end
  end

  // Decision buffer carries no reset; it is always fully rewritten before EMIT.
  always_ff @(posedge clk) begin
    if ((fsm == WAIT) && keep) buf_r[wr_idx[RIW-1:0]] <= trel_r[SW-1];
  end

  assign bus.sm_re     = (fsm == READ) && !abort;
  assign bus.sm_page   = page_r;
  assign bus.sm_state  = trel_r;
  assign bus.out_valid = (fsm == EMIT) && !abort;
  assign bus.out_bit   = (fsm == EMIT) ? buf_r[rd_idx] : 1'b0;
  assign bus.out_last  = (fsm == EMIT) && (rd_idx == '0);
  assign busy          = (fsm != IDLE);

  param_ok: assert property (@(posedge clk) disable iff (reset)
    (OUT_LEN >= 1) && (OUT_LEN <= TBD) && (TBD >= 2) && (TBD <= (1 << PW)));

endmodule

// File: tb/tb_viterbi_traceback_param.sv
module tb_viterbi_traceback_param;
  localparam int SW = 6, PW = 6, TBD = 64, OUT_LEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [SW-1:0] start_state = '0;
  logic [PW-1:0] start_page = '0;
  logic terminate = 1'b0;
  logic abort = 1'b0;
  logic busy, overrun;

  viterbi_traceback_param_if #(.SW(SW), .PW(PW)) bus ();

  viterbi_traceback_param #(.SW(SW), .PW(PW), .TBD(TBD), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .start_state(start_state),
    .start_page(start_page), .terminate(terminate), .abort(abort),
    .bus(bus.master), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc = 0, last_rd_cyc = 0, blk_xfer = 0;
  logic lat_pending = 1'b0, first_rd = 1'b0, rnd_ready = 1'b0;
  logic [63:0] src = 64'hA5A5_0F0F_3C3C_FFFF;
  logic [11:0] rd_q[$];
  logic [1:0]  out_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Encoder-side view: state at page p holds source bits p..p-5, newest in MSB.
  function automatic logic [SW-1:0] true_state(input int p);
    logic [SW-1:0] s;
    for (int i = 0; i < SW; i++) s[i] = src[(p - (SW - 1 - i) + 64) % 64];
    return s;
  endfunction

  // Survivor memory: decision bit is the source bit that falls off the state.
  initial begin
    logic re;
    logic [PW-1:0] pg;
    bus.sm_bit = 1'b0;
    forever begin
      @(negedge clk);
      re = bus.sm_re;
      pg = bus.sm_page;
      @(posedge clk);
      #1 bus.sm_bit = re ? src[(int'(pg) - SW + 64) % 64] : 1'b0;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Read-bus monitor.
  always @(negedge clk) begin
    if (bus.sm_re && !reset) begin
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        logic [11:0] e;
        e = rd_q.pop_front();
        chk("sm_page", bus.sm_page, e[11:6]);
        chk("sm_state", bus.sm_state, e[5:0]);
        if (!first_rd) chk("rd_gap", cyc - last_rd_cyc, 2);
        first_rd = 1'b0;
        last_rd_cyc = cyc;
      end
    end
  end

  // Output-stream monitor: compare against the queue head every valid cycle,
  // so a stalled bit must match the same expected value until accepted.
  always @(negedge clk) begin
    if (bus.out_valid && !reset) begin
      if (lat_pending) begin
        chk("latency", cyc - start_cyc, 2 * TBD);
        lat_pending = 1'b0;
      end
      if (out_q.size() == 0) chk("out_extra", 1, 0);
      else begin
        chk("out_bit", bus.out_bit, out_q[0][0]);
        chk("out_last", bus.out_last, out_q[0][1]);
        if (bus.out_ready) begin
          void'(out_q.pop_front());
          blk_xfer++;
        end
      end
    end
  end

  task automatic do_start(input int p, input logic [SW-1:0] st, input logic term);
    @(posedge clk);
    #1;
    start = 1'b1; start_page = PW'(p); start_state = st; terminate = term;
    start_cyc = cyc + 1;
    lat_pending = 1'b1;
    first_rd = 1'b1;
    blk_xfer = 0;
    for (int k = 0; k < TBD; k++) begin
      int pg;
      pg = (p - k + 64) % 64;
      rd_q.push_back({6'(pg), true_state(pg)});
    end
    for (int j = 0; j < OUT_LEN; j++)
      out_q.push_back({(j == OUT_LEN - 1), src[(p + 1 + j) % 64]});
    @(posedge clk);
    #1 start = 1'b0; terminate = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((out_q.size() != 0 || rd_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", out_q.size() + rd_q.size(), 0);
    @(negedge clk);
    chk("busy_end", busy, 0);
    chk("valid_end", bus.out_valid, 0);
  endtask

  task automatic wait_read();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sm_re && n < 20);
    chk("rd_wait", bus.sm_re, 1);
  endtask

  task automatic flush();
    rd_q.delete();
    out_q.delete();
    lat_pending = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sm_re", bus.sm_re, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_bit", bus.out_bit, 0);
    chk("rst_page", bus.sm_page, 0);
    chk("rst_state", bus.sm_state, 0);
    reset = 1'b0;

    // Basic traceback from page 63.
    do_start(63, true_state(63), 1'b0);
    wait_done(400);

    // Page wrap-around.
    do_start(5, true_state(5), 1'b0);
    wait_done(400);

    // Zero-tail termination overrides the supplied start state.
    src = 64'hA5A5_0F0F_3C3C_FFFF & 64'h03FF_FFFF_FFFF_FFFF;
    do_start(63, 6'h2A, 1'b1);
    wait_done(400);
    src = 64'hA5A5_0F0F_3C3C_FFFF;

    // Random backpressure.
    rnd_ready = 1'b1;
    do_start(40, true_state(40), 1'b0);
    wait_done(800);
    rnd_ready = 1'b0;

    // Start during WAIT is ignored and flags overrun.
    chk("ovr_pre", overrun, 0);
    do_start(17, true_state(17), 1'b0);
    wait_read();
    @(posedge clk);
    #1 start = 1'b1; start_page = 6'd3; start_state = 6'h15;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    wait_done(400);
    chk("ovr_sticky", overrun, 1);

    // Abort in EMIT after 10 bits.
    do_start(63, true_state(63), 1'b0);
    begin
      int n = 0;
      while (blk_xfer < 10 && n < 400) begin
        @(posedge clk);
        n++;
      end
      chk("abort_reach", blk_xfer, 10);
    end
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    flush();
    @(negedge clk);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    do_start(9, true_state(9), 1'b0);
    wait_done(400);

    // Asynchronous reset in the middle of READ.
    do_start(63, true_state(63), 1'b0);
    wait_read();
    #2 reset = 1'b1;
    #1;
    chk("arst_sm_re", bus.sm_re, 0);
    chk("arst_busy", busy, 0);
    chk("arst_page", bus.sm_page, 0);
    chk("arst_state", bus.sm_state, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_valid", bus.out_valid, 0);
    flush();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Recovery after reset.
    do_start(30, true_state(30), 1'b0);
    wait_done(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
